// File: rtl/uart_pkg.sv
// Shared 8N1 serial-link definitions used by both the byte receiver and transmitter.
package uart_pkg;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 10417;  // 9600 baud from 100 MHz
  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned STOP_BITS            = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b11,
    STOP  = 2'b10
  } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous bit, with selectable reset value.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= RESET_VAL;
      q  <= RESET_VAL;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: centre-samples each bit of RXD and emits a data or framing-error strobe per frame.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

  uart_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             s2;
  logic             prev;
  logic             start_edge;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rxd),
    .q    (s2)
  );

  // History flop resets high so a low line at reset release is not taken as a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b1;
    else        prev <= s2;
  end

  assign start_edge = prev & ~s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_edge) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            if (s2) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            shreg   <= {s2, shreg[7:1]};
            cnt     <= '0;
            bit_idx <= bit_idx + 3'(1);
            if (bit_idx == IDX_LAST) state <= STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          // Leave at mid-stop-bit so a back-to-back start bit is still caught.
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
            if (s2) begin
              data_out   <= shreg;
              data_valid <= 1'b1;
            end else begin
              frame_err  <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte: line-level timing model checked every cycle, plus fixed scenario checks.
module tb_uart_rx_byte;

  localparam int unsigned C = 16;
  localparam int unsigned H = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxd;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  always #5 clk = ~clk;

  uart_rx_byte #(
    .CLKS_PER_BIT(C)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  int          tests = 0;
  int          errs  = 0;
  int unsigned cyc   = 0;

  // Model state: line history r[n-1..n-3] and the frame start time in absolute cycles.
  bit          h1 = 1'b1, h2 = 1'b1, h3 = 1'b1;
  bit          m_busy = 1'b0;
  int unsigned t0 = 0;
  logic [7:0]  m_byte = '0;
  logic [7:0]  m_data = '0;
  bit          m_dv = 1'b0;
  bit          m_fe = 1'b0;

  int unsigned dv_cyc[$];
  logic [7:0]  dv_val[$];
  int unsigned fe_cyc[$];
  bit          busy_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Receiver behaviour in absolute time: the edge E0+2 starts a frame, bit centres follow at fixed offsets.
  task automatic model_step();
    int unsigned k;
    int unsigned idx;
    cyc++;
    if (!rst_n) begin
      m_busy = 1'b0;
      h1 = 1'b1; h2 = 1'b1; h3 = 1'b1;
      m_byte = '0; m_data = '0;
      m_dv = 1'b0; m_fe = 1'b0;
      return;
    end
    m_dv = 1'b0;
    m_fe = 1'b0;
    if (!m_busy) begin
      if (h3 && !h2) begin
        m_busy = 1'b1;
        t0 = cyc;
      end
    end else begin
      k = cyc - t0;
      if (k == H) begin
        if (h2) m_busy = 1'b0;
      end else if (k > H && ((k - H) % C) == 0) begin
        idx = (k - H) / C;
        if (idx <= 8) begin
          m_byte[idx-1] = h2;
        end else begin
          if (h2) begin
            m_data = m_byte;
            m_dv = 1'b1;
          end else begin
            m_fe = 1'b1;
          end
          m_busy = 1'b0;
        end
      end
    end
    h3 = h2;
    h2 = h1;
    h1 = rxd;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("reset_data_out", data_out, 8'h00);
        check("reset_data_valid", data_valid, 1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        check("reset_busy", busy, 1'b0);
      end else begin
        check("data_out", data_out, m_data);
        check("data_valid", data_valid, m_dv);
        check("frame_err", frame_err, m_fe);
        check("busy", busy, m_busy);
        check("strobe_exclusive", data_valid & frame_err, 1'b0);
      end
      if (data_valid) begin
        dv_cyc.push_back(cyc);
        dv_val.push_back(data_out);
      end
      if (frame_err) fe_cyc.push_back(cyc);
      if (busy) busy_seen = 1'b1;
    end
  end

  // All drive tasks are entered and left just after a rising edge.
  task automatic bit_out(input logic v);
    rxd = v;
    repeat (C) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    rxd = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic stop, output int unsigned e0);
    e0 = cyc + 1;
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    bit_out(stop);
  endtask

  task automatic clear_log();
    dv_cyc.delete();
    dv_val.delete();
    fe_cyc.delete();
    busy_seen = 1'b0;
  endtask

  initial begin
    int unsigned e0, e1;
    logic [7:0]  rb;
    logic        rs;
    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Idle line after reset
    idle(60);
    check("idle_data_out", data_out, 8'h00);
    check("idle_dv_count", dv_cyc.size(), 0);
    check("idle_fe_count", fe_cyc.size(), 0);
    check("idle_busy_seen", busy_seen, 1'b0);
    clear_log();

    // Single frame 0xA5
    send(8'hA5, 1'b1, e0);
    idle(20);
    check("a5_dv_count", dv_cyc.size(), 1);
    check("a5_latency", dv_cyc[0] - e0, 154);
    check("a5_value", dv_val[0], 8'hA5);
    check("a5_fe_count", fe_cyc.size(), 0);
    clear_log();

    // Back-to-back 0x3C, 0xFF
    send(8'h3C, 1'b1, e0);
    send(8'hFF, 1'b1, e1);
    idle(20);
    check("b2b_dv_count", dv_cyc.size(), 2);
    check("b2b_first_latency", dv_cyc[0] - e0, 154);
    check("b2b_spacing", dv_cyc[1] - dv_cyc[0], 160);
    check("b2b_first_value", dv_val[0], 8'h3C);
    check("b2b_second_value", dv_val[1], 8'hFF);
    clear_log();

    // Framing error, then a held-low break, then a good frame
    send(8'h55, 1'b0, e0);
    check("ferr_count", fe_cyc.size(), 1);
    check("ferr_latency", fe_cyc[0] - e0, 154);
    check("ferr_data_kept", data_out, 8'hFF);
    check("ferr_no_dv", dv_cyc.size(), 0);
    rxd = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    idle(30);
    check("break_fe_count", fe_cyc.size(), 1);
    check("break_dv_count", dv_cyc.size(), 0);
    check("break_busy", busy, 1'b0);
    send(8'h12, 1'b1, e0);
    idle(10);
    check("after_break_dv_count", dv_cyc.size(), 1);
    check("after_break_value", dv_val[0], 8'h12);
    clear_log();

    // Five-cycle glitch from idle
    rxd = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    idle(30);
    check("glitch_busy_seen", busy_seen, 1'b1);
    check("glitch_busy_clear", busy, 1'b0);
    check("glitch_dv_count", dv_cyc.size(), 0);
    check("glitch_fe_count", fe_cyc.size(), 0);
    clear_log();

    // Reset during data bit 4 of 0xF0
    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(1'b0);
    rxd = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("midrst_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_data_out", data_out, 8'h00);
    check("midrst_busy", busy, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(5 + 4 * C + 20);
    check("midrst_dv_count", dv_cyc.size(), 0);
    check("midrst_fe_count", fe_cyc.size(), 0);
    send(8'h81, 1'b1, e0);
    idle(10);
    check("post_rst_dv_count", dv_cyc.size(), 1);
    check("post_rst_latency", dv_cyc[0] - e0, 154);
    check("post_rst_value", dv_val[0], 8'h81);
    clear_log();

    // Random frames, stop errors, gaps and glitches against the model
    for (int n = 0; n < 24; n++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 4) != 0);
      send(rb, rs, e0);
      if ($urandom_range(0, 5) == 0) begin
        idle($urandom_range(1, 10));
        rxd = 1'b0;
        repeat ($urandom_range(1, 7)) @(posedge clk);
        #1;
      end
      idle($urandom_range(0, 20));
    end
    idle(200);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
